// File: rtl/rc4_session_driver_if.sv
// rtl/rc4_session_driver_if.sv - host key/data handshake bundle for rc4_session_driver
interface rc4_session_driver_if;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_last;
    logic       key_ready;
    logic       key_err;
    logic       restart;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout;
    logic       dout_ready;

    modport master (
        output key_valid, key_data, key_last, restart, din_valid, din, dout_ready,
        input  key_ready, key_err, din_ready, dout_valid, dout
    );

    modport slave (
        input  key_valid, key_data, key_last, restart, din_valid, din, dout_ready,
        output key_ready, key_err, din_ready, dout_valid, dout
    );
endinterface

// File: rtl/rc4_session_driver.sv
// rtl/rc4_session_driver.sv - RC4 core session controller with keystream FIFO and stallable XOR channel
// Optional RC4-drop[DROP_N] discard enabled by defining RC4_DROP_EN.
module rc4_session_driver #(
    parameter int KEY_MAX    = 255,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_N     = 768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rc4_session_driver_if.slave   host,
    output logic                  c_rst,
    output logic [7:0]            c_in,
    input  logic [7:0]            c_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef RC4_DROP_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif
    localparam logic [31:0] SKIP_BASE = DROP_ON ? 32'(DROP_N) : 32'd0;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KSA, S_SKIP, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  key_cnt_q, key_cnt_d;
    logic [7:0]  ld_idx_q, ld_idx_d;
    logic [8:0]  ksa_cnt_q, ksa_cnt_d;
    logic [31:0] skip_cnt_q, skip_cnt_d;
    logic [31:0] pos_q, pos_d;
    logic        c_rst_q, c_rst_d;
    logic [7:0]  c_in_q, c_in_d;
    logic        key_err_q, key_err_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  key_buf_q [KEY_MAX];
    logic [7:0]  key_buf_d [KEY_MAX];
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [7:0]  fifo_d [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, din_ready_w, accept, overflow;
    logic [31:0] skip_total;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign din_ready_w = !fifo_empty && (!dout_valid_q || host.dout_ready);
    assign accept      = host.din_valid && din_ready_w;
    // A full FIFO with a same-cycle pop still has room for the incoming byte.
    assign overflow    = (state_q == S_RUN) && fifo_full && !accept;
    assign skip_total  = pos_q + SKIP_BASE;

    assign host.key_ready  = (state_q == S_IDLE);
    assign host.key_err    = key_err_q;
    assign host.din_ready  = din_ready_w;
    assign host.dout_valid = dout_valid_q;
    assign host.dout       = dout_q;
    assign c_rst           = c_rst_q;
    assign c_in            = c_in_q;

    always_comb begin
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        ld_idx_d     = ld_idx_q;
        ksa_cnt_d    = ksa_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        pos_d        = pos_q;
        c_rst_d      = c_rst_q;
        c_in_d       = c_in_q;
        key_err_d    = key_err_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        key_buf_d    = key_buf_q;
        fifo_d       = fifo_q;

        if (accept) begin
            dout_d       = host.din ^ fifo_q[rd_ptr_q[AW-1:0]];
            dout_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
        end else if (host.dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (host.key_valid) begin
                    if (key_cnt_q == 8'(KEY_MAX)) begin
                        key_err_d = 1'b1;
                        key_cnt_d = 8'd0;
                    end else begin
                        key_buf_d[key_cnt_q] = host.key_data;
                        key_cnt_d            = key_cnt_q + 8'd1;
                        if (host.key_last) begin
                            state_d  = S_LOAD;
                            c_rst_d  = 1'b1;
                            c_in_d   = (key_cnt_q == 8'd0) ? host.key_data : key_buf_q[0];
                            ld_idx_d = 8'd1;
                        end
                    end
                end else if (host.key_last) begin
                    if (key_cnt_q == 8'd0) begin
                        key_err_d = 1'b1;
                    end else begin
                        state_d  = S_LOAD;
                        c_rst_d  = 1'b1;
                        c_in_d   = key_buf_q[0];
                        ld_idx_d = 8'd1;
                    end
                end
            end
            S_LOAD: begin
                if (ld_idx_q == key_cnt_q) begin
                    state_d   = S_KSA;
                    c_rst_d   = 1'b0;
                    c_in_d    = 8'h00;
                    ksa_cnt_d = 9'd0;
                end else begin
                    c_in_d   = key_buf_q[ld_idx_q];
                    ld_idx_d = ld_idx_q + 8'd1;
                end
            end
            S_KSA: begin
                // 256 KSA cycles plus the core's one-cycle output latency before byte 0.
                if (ksa_cnt_q == 9'd256) begin
                    if (skip_total == 32'd0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d    = S_SKIP;
                        skip_cnt_d = skip_total;
                    end
                end else begin
                    ksa_cnt_d = ksa_cnt_q + 9'd1;
                end
            end
            S_SKIP: begin
                skip_cnt_d = skip_cnt_q - 32'd1;
                if (skip_cnt_q == 32'd1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (overflow) begin
                    state_d  = S_LOAD;
                    c_rst_d  = 1'b1;
                    c_in_d   = key_buf_q[0];
                    ld_idx_d = 8'd1;
                end else begin
                    fifo_d[wr_ptr_q[AW-1:0]] = c_out;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    pos_d    = pos_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (host.restart) begin
            state_d      = S_IDLE;
            key_cnt_d    = 8'd0;
            pos_d        = 32'd0;
            c_rst_d      = 1'b0;
            c_in_d       = 8'h00;
            key_err_d    = 1'b0;
            dout_d       = 8'h00;
            dout_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            key_cnt_q    <= 8'd0;
            ld_idx_q     <= 8'd0;
            ksa_cnt_q    <= 9'd0;
            skip_cnt_q   <= 32'd0;
            pos_q        <= 32'd0;
            c_rst_q      <= 1'b0;
            c_in_q       <= 8'h00;
            key_err_q    <= 1'b0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            key_cnt_q    <= key_cnt_d;
            ld_idx_q     <= ld_idx_d;
            ksa_cnt_q    <= ksa_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            pos_q        <= pos_d;
            c_rst_q      <= c_rst_d;
            c_in_q       <= c_in_d;
            key_err_q    <= key_err_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        key_buf_q <= key_buf_d;
        fifo_q    <= fifo_d;
    end

endmodule
